// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time loadable PAT_W-bit pattern, overlapping or non-overlapping matching.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter; otherwise match_count reads 0.
module seq_detector_param #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   RST_PAT = PAT_W'(4'b0110),
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             in_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pat_load,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_reg, pat_next;
    logic [PAT_W-1:0]  hist_reg, hist_next;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [FILL_W-1:0] fill_inc;
    logic              z_reg, z_next;
    logic              match;

    // Oldest bit ends up in the MSB so the history lines up with pattern[PAT_W-1] first.
    assign hist_shift[0] = x;
    generate
        for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
            assign hist_shift[gi] = hist_reg[gi-1];
        end
    endgenerate

    assign fill_inc = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
    assign match    = in_valid && !pat_load && (fill_inc == FILL_FULL) && (hist_shift == pat_reg);

    always_comb begin
        pat_next  = pat_reg;
        hist_next = hist_reg;
        fill_next = fill_reg;
        z_next    = 1'b0;
        if (pat_load) begin
            pat_next  = pattern;
            hist_next = '0;
            fill_next = '0;
        end else if (in_valid) begin
            hist_next = hist_shift;
            fill_next = (match && !overlap_en) ? '0 : fill_inc;
            z_next    = match;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_reg  <= RST_PAT;
            hist_reg <= '0;
            fill_reg <= '0;
            z_reg    <= 1'b0;
        end else begin
            pat_reg  <= pat_next;
            hist_reg <= hist_next;
            fill_reg <= fill_next;
            z_reg    <= z_next;
        end
    end

    assign z     = z_reg;
    assign armed = (fill_reg == FILL_FULL);

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Clear beats a coincident match; the count sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (match && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign match_count = cnt_reg;
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
    assign match_count    = '0;
`endif

endmodule
